// File: rtl/tcp_vlg_pkg.sv
// Shared types for the TCP transmit path.
// Holds the feeder FSM state encoding and a counter-width helper.
package tcp_vlg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } feeder_state_e;

    // Bits needed to hold 0..max_v+1 without wrapping.
    function automatic int cnt_width(input int max_v);
        return $clog2(max_v + 2);
    endfunction

endpackage

// File: rtl/tcp_tx_feeder_fifo.sv
// Byte FIFO for the TCP transmit feeder: simple dual-port RAM with a
// registered read port and wrap-around pointers carrying an extra MSB.
// Ports:
//   clk, rst            core clock, async active-low reset
//   clr_i               synchronous pointer clear (discards content)
//   wr_en_i, wr_data_i  write strobe and byte
//   rd_en_i, rd_data_o  read strobe; byte is presented the next cycle
//   level_o             occupancy, 0..2**DEPTH_LOG2
//   full_o, empty_o     occupancy flags
module tcp_tx_feeder_fifo #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [7:0]            wr_data_i,
    input  logic                  rd_en_i,
    output logic [7:0]            rd_data_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q;
    logic [DEPTH_LOG2:0] wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q;
    logic [DEPTH_LOG2:0] rd_ptr_d;
    logic [7:0]          rd_data_q;
    logic                wr_ok;
    logic                rd_ok;

    // Pointer difference modulo 2**(DEPTH_LOG2+1); the extra MSB
    // separates full (difference = DEPTH) from empty (difference = 0).
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (level_o == FULL_LVL);
    assign empty_o   = (level_o == '0);
    assign rd_data_o = rd_data_q;

    assign wr_ok = wr_en_i && !full_o && !clr_i;
    assign rd_ok = rd_en_i && !empty_o && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (rd_ok) rd_data_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
        end
    end

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/tcp_tx_feeder.sv
// Buffers user bytes and feeds them to the TCP core, forcing a send after
// FLUSH_BYTES beats or FLUSH_TICKS idle cycles with data pending.
// Ports:
//   clk, rst       core clock, async active-low reset
//   connected      TCP connection established
//   din, vin, rdy  user byte stream in; rdy = FIFO can take a byte
//   dout, vout     byte stream to tcp_din / tcp_vin
//   cts            tcp_cts clear-to-send
//   snd            one-cycle tcp_snd force-send pulse
//   level          FIFO occupancy
//   overflow       sticky: a byte was dropped while full
// Optional macro TCP_TX_FEEDER_STATS_EN adds saturating stat_bytes
// (vout beats) and stat_drops (dropped bytes), cleared only by rst.
module tcp_tx_feeder
    import tcp_vlg_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int FLUSH_TICKS = 125,
    parameter int FLUSH_BYTES = 1460
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                connected,
    input  logic [7:0]          din,
    input  logic                vin,
    output logic                rdy,
    output logic [7:0]          dout,
    output logic                vout,
    input  logic                cts,
    output logic                snd,
    output logic [DEPTH_LOG2:0] level,
    output logic                overflow
`ifdef TCP_TX_FEEDER_STATS_EN
    ,
    output logic [31:0]         stat_bytes,
    output logic [15:0]         stat_drops
`endif
);

    localparam int BW = cnt_width(FLUSH_BYTES);
    localparam int TW = cnt_width(FLUSH_TICKS);
    localparam logic [BW-1:0] FB_LIM = BW'(FLUSH_BYTES);
    localparam logic [TW-1:0] FT_LIM = TW'(FLUSH_TICKS);

    feeder_state_e state_q;
    feeder_state_e state_d;
    logic [BW-1:0] bcnt_q;
    logic [BW-1:0] bcnt_d;
    logic [TW-1:0] icnt_q;
    logic [TW-1:0] icnt_d;
    logic          vout_q;
    logic          ovf_q;

    logic                active;
    logic                wr_en;
    logic                rd_en;
    logic                drop;
    logic                full;
    logic                empty;
    logic [7:0]          rd_data;
    logic [DEPTH_LOG2:0] fifo_lvl;

    // A falling connected gates all traffic in the same cycle so the
    // pointer clear and the IDLE entry land on the same edge.
    assign active = (state_q != IDLE) && connected;
    assign wr_en  = active && vin && !full;
    assign drop   = active && vin && full;
    assign rd_en  = active && cts && !empty;

    assign rdy      = active && !full;
    assign dout     = rd_data;
    assign vout     = vout_q;
    assign snd      = (state_q == FLUSH);
    assign level    = fifo_lvl;
    assign overflow = ovf_q;

    tcp_tx_feeder_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!active),
        .wr_en_i   (wr_en),
        .wr_data_i (din),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_data),
        .level_o   (fifo_lvl),
        .full_o    (full),
        .empty_o   (empty)
    );

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        icnt_d  = icnt_q;
        if (!connected) begin
            state_d = IDLE;
            bcnt_d  = '0;
            icnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RUN;
                    bcnt_d  = '0;
                    icnt_d  = '0;
                end
                // A beat coinciding with the send pulse opens the next
                // segment rather than being lost.
                FLUSH: begin
                    state_d = RUN;
                    bcnt_d  = vout_q ? BW'(1) : '0;
                    icnt_d  = '0;
                end
                RUN: begin
                    if (vout_q) begin
                        bcnt_d = bcnt_q + 1'b1;
                        icnt_d = '0;
                    end else if (bcnt_q != '0) begin
                        icnt_d = icnt_q + 1'b1;
                    end
                    // Both triggers share one transition: a single pulse.
                    if (bcnt_d >= FB_LIM || icnt_d >= FT_LIM) begin
                        state_d = FLUSH;
                    end
                end
                default: begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                    icnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            icnt_q  <= '0;
            vout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            icnt_q  <= icnt_d;
            vout_q  <= rd_en;
            if (drop) ovf_q <= 1'b1;
        end
    end

`ifdef TCP_TX_FEEDER_STATS_EN
    logic [31:0] sbytes_q;
    logic [15:0] sdrops_q;

    assign stat_bytes = sbytes_q;
    assign stat_drops = sdrops_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sbytes_q <= '0;
            sdrops_q <= '0;
        end else begin
            if (vout_q && sbytes_q != '1) sbytes_q <= sbytes_q + 1'b1;
            if (drop && sdrops_q != '1) sdrops_q <= sdrops_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tcp_tx_feeder.sv
// Self-checking bench for tcp_tx_feeder.
// Scoreboard of expected bytes plus a queue-based reference model.
module tb_tcp_tx_feeder;

    localparam int DL    = 3;
    localparam int DEPTH = 8;
    localparam int FT    = 8;
    localparam int FB    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          connected = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          vin = 1'b0;
    logic          cts = 1'b0;
    logic          rdy;
    logic [7:0]    dout;
    logic          vout;
    logic          snd;
    logic [DL:0]   level;
    logic          overflow;

    always #5 clk = ~clk;

    tcp_tx_feeder #(
        .DEPTH_LOG2  (DL),
        .FLUSH_TICKS (FT),
        .FLUSH_BYTES (FB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .connected (connected),
        .din       (din),
        .vin       (vin),
        .rdy       (rdy),
        .dout      (dout),
        .vout      (vout),
        .cts       (cts),
        .snd       (snd),
        .level     (level),
        .overflow  (overflow)
    );

    int total = 0;
    int bad   = 0;
    int n_snd = 0;
    int n_beat = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue of bytes, the scoreboard a
    // queue of bytes already read and due on vout in the next cycle.
    byte unsigned fifo_m[$];
    byte unsigned sb_q[$];
    bit  prev_conn = 0;
    bit  m_vout = 0;
    bit  m_snd = 0;
    bit  m_ovf = 0;
    int  m_bc = 0;
    int  m_ic = 0;
    bit  m_act;
    bit  m_beat;
    int  m_sz;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_m.delete();
            sb_q.delete();
            prev_conn = 0;
            m_vout = 0;
            m_snd = 0;
            m_ovf = 0;
            m_bc = 0;
            m_ic = 0;
        end else begin
            // Streaming only after a cycle already spent connected.
            m_act  = prev_conn && connected;
            m_beat = m_vout;
            if (!m_act) begin
                m_bc = 0;
                m_ic = 0;
                m_snd = 0;
            end else if (m_snd) begin
                m_bc = m_beat ? 1 : 0;
                m_ic = 0;
                m_snd = 0;
            end else begin
                if (m_beat) begin
                    m_bc = m_bc + 1;
                    m_ic = 0;
                end else if (m_bc > 0) begin
                    m_ic = m_ic + 1;
                end
                m_snd = (m_bc >= FB) || (m_ic >= FT);
            end
            m_sz = fifo_m.size();
            m_vout = 0;
            if (!m_act) begin
                fifo_m.delete();
            end else begin
                if (cts && m_sz > 0) begin
                    sb_q.push_back(fifo_m.pop_front());
                    m_vout = 1;
                end
                if (vin) begin
                    if (m_sz < DEPTH) fifo_m.push_back(din);
                    else m_ovf = 1;
                end
            end
            prev_conn = connected;
        end
    end

    // Monitor: compares everything the DUT presents each cycle.
    always @(negedge clk) begin
        chk("vout", 32'(vout), 32'(m_vout));
        if (vout === 1'b1) begin
            n_beat++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dout: got %0h expected no beat", dout);
            end else begin
                chk("dout", 32'(dout), 32'(sb_q.pop_front()));
            end
        end
        if (snd === 1'b1) n_snd++;
        chk("level", 32'(level), 32'(fifo_m.size()));
        chk("snd", 32'(snd), 32'(m_snd));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("rdy", 32'(rdy),
            32'(rst && prev_conn && connected && fifo_m.size() < DEPTH));
    end

    task automatic step(input logic c, input logic v, input logic [7:0] d,
                        input logic t);
        connected = c;
        vin = v;
        din = d;
        cts = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_rdy", 32'(rdy), 32'd0);
        repeat (3) step(0, 0, 8'h00, 0);
        rst = 1'b1;
        step(0, 0, 8'h00, 0);

        // 0x00..0x09 with cts=1: snd after beat 4, 8, then idle timeout.
        step(1, 0, 8'h00, 1);
        n_snd = 0;
        for (int i = 0; i < 10; i++) step(1, 1, 8'(i), 1);
        repeat (20) step(1, 0, 8'h00, 1);
        chk("p1_snd_count", 32'(n_snd), 32'd3);

        // Overflow: 9 writes into an 8-deep FIFO with cts=0.
        for (int i = 0; i < 9; i++) step(1, 1, 8'(8'hA0 + i), 0);
        chk("full_level", 32'(level), 32'd8);
        chk("full_rdy", 32'(rdy), 32'd0);
        chk("full_ovf", 32'(overflow), 32'd1);
        repeat (14) step(1, 0, 8'h00, 1);
        chk("drained", 32'(level), 32'd0);

        // cts toggling every cycle over 20 bytes.
        n_beat = 0;
        for (int i = 0; i < 40; i++)
            step(1, (i % 2) == 0, 8'(8'h40 + i / 2), (i % 2) == 1);
        repeat (12) step(1, 0, 8'h00, 1);
        chk("toggle_beats", 32'(n_beat), 32'd20);

        // Disconnect with 5 bytes queued.
        for (int i = 0; i < 5; i++) step(1, 1, 8'(8'h70 + i), 0);
        chk("pre_drop_level", 32'(level), 32'd5);
        n_snd = 0;
        step(0, 0, 8'h00, 0);
        chk("drop_level", 32'(level), 32'd0);
        chk("drop_vout", 32'(vout), 32'd0);
        chk("drop_snd", 32'(n_snd), 32'd0);
        repeat (3) step(0, 0, 8'h00, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) != 0, 1'($urandom_range(0, 1)),
                 8'($urandom), $urandom_range(0, 3) != 0);

        // Asynchronous reset mid-stream.
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 8'(8'hC0 + i), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_rdy", 32'(rdy), 32'd0);
        chk("arst_vout", 32'(vout), 32'd0);
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_snd", 32'(snd), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++)
            step(1, 1'($urandom_range(0, 1)), 8'($urandom), 1);
        repeat (30) step(1, 0, 8'h00, 1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
